// File: rtl/gin_bus_dispatcher_pkg.sv
// Shared types for the GIN bus dispatcher.
// State encoding and packet width helper.
package gin_bus_dispatcher_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_CONFIG = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DRAIN  = ST_DRAIN,
    CONFIG = ST_CONFIG,
    RUN    = ST_RUN
  } state_t;

  function automatic int pkt_width(
    input int value_len,
    input int id_len
  );
    return value_len + id_len + 1;
  endfunction

endpackage

// File: rtl/gin_dispatch_fifo.sv
// Synchronous FIFO, power-of-2 depth.
// Ports: push/wdata, pop/rdata (head), full, empty, count.
module gin_dispatch_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/gin_bus_dispatcher.sv
// Programs a GIN row's ID scan chain, then streams packets onto the bus.
// Ports: cfg_* (ID programming), in_* (packets), bus_* (GIN bus), busy.
module gin_bus_dispatcher
  import gin_bus_dispatcher_pkg::*;
#(
  parameter int MASTER_NUMS = 14,
  parameter int ID_LEN      = 5,
  parameter int VALUE_LEN   = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_start,
  input  logic                                  cfg_id_valid,
  input  logic [ID_LEN-1:0]                     cfg_id_data,
  output logic                                  cfg_id_ready,
  output logic                                  cfg_done,
  input  logic                                  in_valid,
  input  logic [ID_LEN-1:0]                     in_tag,
  input  logic [VALUE_LEN-1:0]                  in_value,
  output logic                                  in_ready,
  output logic [pkt_width(VALUE_LEN,ID_LEN)-1:0] bus_enable_tag_value,
  input  logic                                  bus_ready,
  output logic                                  bus_set_id,
  output logic [ID_LEN-1:0]                     bus_id_scan,
  output logic                                  busy
);

  localparam int DW  = VALUE_LEN + ID_LEN;
  localparam int CNW = (MASTER_NUMS > 1) ? $clog2(MASTER_NUMS) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_t           state;
  logic [CNW-1:0]   cfg_cnt;
  logic             cfg_last;
  logic             beat;
  logic             push;
  logic             pop;
  logic             bus_en;
  logic             full;
  logic             empty;
  logic [FCW-1:0]   count;
  logic [DW-1:0]    head;

  // cfg_last blocks further beats while the final strobe is on the chain.
  assign cfg_id_ready = (state == CONFIG) && !cfg_last;
  assign beat         = cfg_id_valid && cfg_id_ready;
  assign in_ready     = (state == RUN) && !full;
  assign push         = in_valid && in_ready;
  assign bus_en       = !empty && ((state == RUN) || (state == DRAIN));
  assign pop          = bus_en && bus_ready;
  assign busy         = (state != RUN);

  assign bus_enable_tag_value = bus_en ? {1'b1, head} : '0;

  gin_dispatch_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_tag, in_value}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cfg_cnt     <= '0;
      cfg_last    <= 1'b0;
      cfg_done    <= 1'b0;
      bus_set_id  <= 1'b0;
      bus_id_scan <= '0;
    end else begin
      cfg_done    <= 1'b0;
      bus_set_id  <= beat;
      bus_id_scan <= beat ? cfg_id_data : '0;
      unique case (state)
        IDLE: begin
          if (cfg_start) state <= CONFIG;
        end
        RUN: begin
          // A same-cycle push must also be drained first.
          if (cfg_start)
            state <= (empty && !push) ? CONFIG : DRAIN;
        end
        DRAIN: begin
          if (empty || (pop && count == FCW'(1)))
            state <= CONFIG;
        end
        CONFIG: begin
          if (cfg_last) begin
            state    <= RUN;
            cfg_last <= 1'b0;
            cfg_done <= 1'b1;
          end else if (beat) begin
            if (cfg_cnt == CNW'(MASTER_NUMS - 1)) begin
              cfg_last <= 1'b1;
              cfg_cnt  <= '0;
            end else begin
              cfg_cnt <= cfg_cnt + CNW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gin_bus_dispatcher.sv
// Scoreboard bench for gin_bus_dispatcher.
// Checks ID strobes, packet order, backpressure, drain and reset.
module tb_gin_bus_dispatcher;

  localparam int MN = 14;
  localparam int IL = 5;
  localparam int VL = 32;
  localparam int FD = 4;
  localparam int PW = VL + IL + 1;

  logic          clk;
  logic          rst;
  logic          cfg_start;
  logic          cfg_id_valid;
  logic [IL-1:0] cfg_id_data;
  logic          cfg_id_ready;
  logic          cfg_done;
  logic          in_valid;
  logic [IL-1:0] in_tag;
  logic [VL-1:0] in_value;
  logic          in_ready;
  logic [PW-1:0] bus_enable_tag_value;
  logic          bus_ready;
  logic          bus_set_id;
  logic [IL-1:0] bus_id_scan;
  logic          busy;

  logic          bus_en;
  assign bus_en = bus_enable_tag_value[PW-1];

  int checks;
  int failures;
  int strobes;
  int dones;
  int pops;

  logic [IL-1:0]    scan_q [$];
  logic [PW-2:0]    bus_q  [$];

  gin_bus_dispatcher #(
    .MASTER_NUMS (MN),
    .ID_LEN      (IL),
    .VALUE_LEN   (VL),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cfg_start            (cfg_start),
    .cfg_id_valid         (cfg_id_valid),
    .cfg_id_data          (cfg_id_data),
    .cfg_id_ready         (cfg_id_ready),
    .cfg_done             (cfg_done),
    .in_valid             (in_valid),
    .in_tag               (in_tag),
    .in_value             (in_value),
    .in_ready             (in_ready),
    .bus_enable_tag_value (bus_enable_tag_value),
    .bus_ready            (bus_ready),
    .bus_set_id           (bus_set_id),
    .bus_id_scan          (bus_id_scan),
    .busy                 (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: push on accepted input, pop on observed output.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_set_id) begin
        strobes++;
        if (scan_q.size() == 0)
          check("scan_unexp", 1, 0);
        else
          check("scan_id", 64'(bus_id_scan), 64'(scan_q.pop_front()));
      end
      if (cfg_id_valid && cfg_id_ready)
        scan_q.push_back(cfg_id_data);
      if (cfg_done) dones++;
      if (in_valid && in_ready)
        bus_q.push_back({in_tag, in_value});
      if (bus_en && bus_ready) begin
        pops++;
        if (bus_q.size() == 0)
          check("pop_unexp", 1, 0);
        else
          check("pop_pkt", 64'(bus_enable_tag_value[PW-2:0]),
                64'(bus_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs();
    check("rst_bus",   64'(bus_enable_tag_value), 0);
    check("rst_cfgrdy", 64'(cfg_id_ready), 0);
    check("rst_done",  64'(cfg_done), 0);
    check("rst_inrdy", 64'(in_ready), 0);
    check("rst_setid", 64'(bus_set_id), 0);
    check("rst_scan",  64'(bus_id_scan), 0);
    check("rst_busy",  64'(busy), 1);
  endtask

  task automatic start_cfg();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("cfg_rdy", 64'(cfg_id_ready), 1);
    check("cfg_busy", 64'(busy), 1);
  endtask

  task automatic send_ids(
    input bit            gap,
    input int            n,
    input logic [IL-1:0] xv
  );
    logic [IL-1:0] id;
    for (int i = 0; i < n; i++) begin
      id           = IL'(MN - 1 - i) ^ xv;
      cfg_id_valid = 1'b1;
      cfg_id_data  = id;
      tick();
      check("strobe", 64'(bus_set_id), 1);
      if (gap && i < n - 1) begin
        cfg_id_valid = 1'b0;
        tick();
        check("gap_nostrobe", 64'(bus_set_id), 0);
      end
    end
    cfg_id_valid = 1'b0;
  endtask

  task automatic finish_cfg();
    check("last_rdy", 64'(cfg_id_ready), 0);
    check("last_nodone", 64'(cfg_done), 0);
    check("last_busy", 64'(busy), 1);
    tick();
    check("done", 64'(cfg_done), 1);
    check("run_busy", 64'(busy), 0);
    check("run_inrdy", 64'(in_ready), 1);
    check("run_setid", 64'(bus_set_id), 0);
    tick();
    check("done_pulse", 64'(cfg_done), 0);
  endtask

  task automatic push_pkt(
    input logic [IL-1:0] t,
    input logic [VL-1:0] v
  );
    in_valid = 1'b1;
    in_tag   = t;
    in_value = v;
    check("push_rdy", 64'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (bus_en && n < 50) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(bus_en), 0);
    check("drain_sb", 64'(bus_q.size()), 0);
  endtask

  initial begin
    int s0;
    int p0;
    int acc;
    bit acc_now;
    checks = 0; failures = 0;
    strobes = 0; dones = 0; pops = 0;
    rst = 1'b1;
    cfg_start = 1'b0; cfg_id_valid = 1'b0; cfg_id_data = '0;
    in_valid = 1'b0; in_tag = '0; in_value = '0; bus_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs();
    rst = 1'b0;
    tick();
    check("idle_inrdy", 64'(in_ready), 0);
    check("idle_cfgrdy", 64'(cfg_id_ready), 0);

    // Program back-to-back, IDs 13..0.
    start_cfg();
    send_ids(1'b0, MN, '0);
    finish_cfg();
    check("strobes_t1", 64'(strobes), MN);

    // Backpressure on three packets.
    bus_ready = 1'b0;
    push_pkt(5'd3, 32'hA);
    check("lat_en", 64'(bus_en), 1);
    push_pkt(5'd7, 32'hB);
    push_pkt(5'd3, 32'hC);
    for (int i = 0; i < 3; i++) begin
      check("hold", 64'(bus_enable_tag_value), {1'b1, 5'd3, 32'hA});
      tick();
    end
    bus_ready = 1'b1;
    drain();
    bus_ready = 1'b0;

    // Fill, refuse fifth, then stream with wrap.
    p0 = pops;
    for (int k = 0; k < FD; k++)
      push_pkt(IL'(k), 32'h100 + k);
    in_valid = 1'b1;
    in_tag   = 5'd4;
    in_value = 32'h104;
    check("full_rdy", 64'(in_ready), 0);
    tick();
    check("full_head", 64'(bus_enable_tag_value), {1'b1, 5'd0, 32'h100});
    bus_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 40 && acc < 10; c++) begin
      in_valid = 1'b1;
      in_tag   = IL'(4 + acc);
      in_value = 32'h104 + acc;
      acc_now  = in_ready;
      tick();
      check("stream_en", 64'(bus_en), 1);
      if (acc_now) acc++;
    end
    check("stream_acc", 64'(acc), 10);
    in_valid = 1'b0;
    drain();
    check("stream_pops", 64'(pops - p0), FD + 10);
    bus_ready = 1'b0;

    // Reprogram with two entries queued, gapped IDs.
    push_pkt(5'd9, 32'h200);
    push_pkt(5'd10, 32'h201);
    cfg_start = 1'b1;
    tick();
    check("drain_busy", 64'(busy), 1);
    check("drain_inrdy", 64'(in_ready), 0);
    check("drain_cfgrdy", 64'(cfg_id_ready), 0);
    check("drain_en", 64'(bus_en), 1);
    s0 = strobes;
    in_valid  = 1'b1;
    in_tag    = 5'd1;
    in_value  = 32'hDEAD;
    bus_ready = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("drain1_cfgrdy", 64'(cfg_id_ready), 0);
    check("drain1_en", 64'(bus_en), 1);
    tick();
    in_valid = 1'b0;
    check("drain_cfg", 64'(cfg_id_ready), 1);
    check("drain_empty", 64'(bus_en), 0);
    check("drain_nostrobe", 64'(strobes - s0), 0);
    check("drain_sb", 64'(bus_q.size()), 0);
    send_ids(1'b1, MN, 5'h15);
    finish_cfg();
    check("strobes_t4", 64'(strobes - s0), MN);

    // Reset in the middle of a programming pass.
    start_cfg();
    send_ids(1'b0, 5, '0);
    rst = 1'b1;
    #2;
    check_reset_outs();
    scan_q.delete();
    bus_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_cfgrdy", 64'(cfg_id_ready), 0);
    start_cfg();
    send_ids(1'b0, MN, 5'h0A);
    finish_cfg();

    bus_ready = 1'b1;
    push_pkt(5'd31, 32'hFFFF_FFFF);
    check("final_en", 64'(bus_en), 1);
    drain();

    check("dones", 64'(dones), 3);
    check("scan_left", 64'(scan_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gin_bus_dispatcher.md
# gin_bus_dispatcher

Controller that sits in front of one GIN bus (one PE-array row). It first programs the row's multicast ID scan chain. It then streams tagged values from an upstream producer onto the bus through a small FIFO, obeying the bus's aggregate `ready`. Reprogramming IDs while traffic is queued is serialized by draining the FIFO first, so no packet is ever broadcast against a half-shifted ID chain.

## Interface
Parameters:
- `MASTER_NUMS`, 14: number of multicast controllers on the bus, which is also the scan-chain length.
- `ID_LEN`, 5: tag/ID width.
- `VALUE_LEN`, 32: payload width.
- `FIFO_DEPTH`, 4: data FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_start` in 1: request to (re)program IDs; sampled when high.
- `cfg_id_valid` in 1: an upstream ID beat is valid.
- `cfg_id_data` in `ID_LEN`: ID beat. The ID for master `MASTER_NUMS-1` is sent first and the ID for master 0 last.
- `cfg_id_ready` out 1: the dispatcher accepts an ID beat this cycle.
- `cfg_done` out 1: one-cycle pulse when programming completes.
- `in_valid` in 1: upstream packet valid.
- `in_tag` in `ID_LEN`: destination tag.
- `in_value` in `VALUE_LEN`: payload.
- `in_ready` out 1: a packet is accepted this cycle.
- `bus_enable_tag_value` out `VALUE_LEN+ID_LEN+1`: drives the bus input as {enable, tag, value}.
- `bus_ready` in 1: the bus aggregate ready.
- `bus_set_id` out 1: scan-chain shift strobe.
- `bus_id_scan` out `ID_LEN`: scan-chain input.
- `busy` out 1: the state is not RUN.

## Operation
- The dispatcher has four states: IDLE (unconfigured, the reset state), DRAIN, CONFIG and RUN.
- **IDLE**
  - `cfg_start` moves to CONFIG.
  - No data is accepted (`in_ready`=0).
- **RUN**
  - `cfg_start` moves to DRAIN if the FIFO is non-empty, otherwise directly to CONFIG.
  - `in_ready` = RUN && !full. A push occurs on `in_valid`&&`in_ready`.
  - `in_ready` is not raised by a simultaneous pop.
- **DRAIN**
  - `in_ready`=0. The FIFO keeps popping to the bus.
  - When the FIFO becomes empty, the state moves to CONFIG.
  - `cfg_start` is ignored while in DRAIN.
- **CONFIG**
  - `cfg_id_ready`=1. A beat is accepted on `cfg_id_valid`, and a counter counts 0..`MASTER_NUMS-1`.
  - Each accepted beat registers `bus_set_id`=1 and `bus_id_scan`=`cfg_id_data` for exactly the next cycle; otherwise `bus_set_id`=0.
  - After beat `MASTER_NUMS-1` is accepted, the state moves to RUN. This is one cycle later than the final strobe.
  - `cfg_start` is ignored while in CONFIG.
- **Bus side**
  - enable = FIFO non-empty && state ∈ {RUN, DRAIN}. Tag and value come from the FIFO head.
  - A pop occurs on enable&&`bus_ready`.
  - While enable=1 and `bus_ready`=0, the tag and value must stay stable.
- **FIFO**
  - Read/write pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap modulo the depth. The count is `$clog2(FIFO_DEPTH)+1` bits.
  - A simultaneous push and pop leaves the count unchanged.

## Timing
- **Reset:** state=IDLE, FIFO empty, counter=0. All outputs are 0 except `busy`=1.
- **Packet latency:** push at cycle t gives enable at t+1 when the FIFO was empty. The head is driven combinationally from the registered storage.
- **Start of programming:** `cfg_start` at t with an empty FIFO in RUN or IDLE gives state=CONFIG and `cfg_id_ready`=1 at t+1.
- **End of programming:** last ID beat accepted at t:
  - `bus_set_id`=1 at t+1.
  - state=RUN at t+2, with `cfg_done`=1 for that cycle only and `in_ready` able to be 1.
- **Drain:** in DRAIN, if the final pop happens at t, the state is CONFIG at t+1.
- **Reset mid-operation:** asynchronous return to the reset values.
  - A partial ID shift is abandoned, and the chain must be reprogrammed.
  - FIFO contents are discarded.
- **Back-to-back programming:** `cfg_id_valid` held high gives one shift per cycle, so `MASTER_NUMS` consecutive strobes.

## Structure
- A shared package holds:
  - the state encoding localparams (IDLE=0, DRAIN=1, CONFIG=2, RUN=3);
  - the packet-width helper `VALUE_LEN+ID_LEN+1`.
- Sub-module `gin_dispatch_fifo`: a parameterized synchronous FIFO (width, depth) with full/empty/count and async active-high reset.
- The FSM, config counter and bus output logic live in the top module.

## Test plan
- **Program, default parameters.** Reset, `cfg_start`, then 14 IDs 13..0 back-to-back.
  - Expect 14 consecutive `bus_set_id` pulses carrying those values.
  - Expect `cfg_done` exactly 1 cycle after the last strobe, and `busy`=0.
- **Stream with backpressure.** In RUN, push tags 3,7,3 with values 0xA,0xB,0xC while `bus_ready` is held low for 3 cycles.
  - Expect enable=1 with {3,0xA} stable for those 3 cycles, then pops in order 0xA, 0xB, 0xC.
- **Full FIFO.** Push 4 with `bus_ready`=0.
  - Expect `in_ready`=0 on the 5th attempt.
  - With `bus_ready`=1 and `in_valid` held, expect one entry per cycle and correct pointer wrap over 10 packets.
- **Reprogram with data queued.** `cfg_start` with 2 entries queued.
  - Expect the state in DRAIN, `in_ready`=0, and both entries delivered.
  - Expect CONFIG the cycle after the last pop, and no `bus_set_id` before then.
- **Gapped IDs.** `cfg_id_valid` toggling 1,0,1,...
  - Expect strobes only after accepted beats, and `cfg_done` after the 14th accepted beat.
- **Reset mid-CONFIG.** Assert `rst` after 5 IDs.
  - Expect all outputs at their reset values immediately.
  - Expect a subsequent full program sequence to complete normally.
